// File: rtl/clock_gen_multi.sv
// Bank of NUM_CH independent, run-time programmable clock dividers with
// glitch-free ratio changes at period boundaries and 50% duty for odd ratios.
`timescale 1ns/1ps

module clock_gen_multi #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 8,
    parameter int CNT_W     = 8,
    parameter int RST_RATIO = 2
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic [NUM_CH*DIV_W-1:0]   div_ratio,
    input  logic [NUM_CH-1:0]         div_load,
    input  logic [NUM_CH-1:0]         ch_en,
    output logic [NUM_CH-1:0]         clk_div,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         cfg_err,
    output logic [NUM_CH*CNT_W-1:0]   toggle_counter
);

    localparam logic [0:0]       ST_IDLE = 1'b0;
    localparam logic [0:0]       ST_RUN  = 1'b1;
    localparam logic [DIV_W-1:0] RST_R   = DIV_W'(RST_RATIO);

    // Number of posedge cycles the primary phase stays high: ceil(r/2).
    function automatic logic [DIV_W:0] high_len(input logic [DIV_W-1:0] r);
        high_len = ({1'b0, r} + (DIV_W+1)'(1)) >> 1;
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [0:0]       state_q, state_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] active_q, active_d;
        logic [DIV_W-1:0] pending_q;
        logic [DIV_W-1:0] ratio_in;
        logic [DIV_W-1:0] next_ratio;
        logic [CNT_W-1:0] tog_q;
        logic             p_q, p_d;
        logic             n_q;
        logic             tick_q;
        logic             err_q;
        logic             load_ok;
        logic             load_bad;
        logic             boundary;
        logic             start;

        assign ratio_in   = div_ratio[i*DIV_W +: DIV_W];
        assign load_ok    = div_load[i] && (ratio_in >= DIV_W'(2));
        assign load_bad   = div_load[i] && (ratio_in <  DIV_W'(2));
        // A valid strobe on the boundary cycle feeds the period starting there.
        assign next_ratio = load_ok ? ratio_in : pending_q;
        assign boundary   = (state_q == ST_RUN) && (cnt_q == active_q - DIV_W'(1));
        assign start      = ch_en[i] && ((state_q == ST_IDLE) || boundary);

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            active_d = active_q;
            if (start) begin
                state_d  = ST_RUN;
                cnt_d    = '0;
                active_d = next_ratio;
            end else if (boundary) begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
            end else if (state_q == ST_RUN) begin
                cnt_d    = cnt_q + DIV_W'(1);
            end
            p_d = (state_d == ST_RUN) && ({1'b0, cnt_d} < high_len(active_d));
        end

        always_ff @(posedge clk_in or negedge rst) begin
            if (!rst) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                active_q  <= RST_R;
                pending_q <= RST_R;
                p_q       <= 1'b0;
                tick_q    <= 1'b0;
                err_q     <= 1'b0;
                tog_q     <= '0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                active_q <= active_d;
                p_q      <= p_d;
                tick_q   <= start;
                if (load_ok)
                    pending_q <= ratio_in;
                if (load_bad)
                    err_q <= 1'b1;
                // Every primary-phase rise produces exactly one clk_div rise.
                if (p_d && !p_q)
                    tog_q <= tog_q + CNT_W'(1);
            end
        end

        // Half-cycle delayed copy trims the odd-ratio high time to exactly R/2.
        always_ff @(negedge clk_in or negedge rst) begin
            if (!rst)
                n_q <= 1'b0;
            else
                n_q <= p_q;
        end

        assign clk_div[i] = active_q[0] ? (p_q & n_q) : p_q;
        assign tick[i]    = tick_q;
        assign cfg_err[i] = err_q;
        assign toggle_counter[i*CNT_W +: CNT_W] = tog_q;
    end

endmodule

// File: tb/tb_clock_gen_multi.sv
// Directed bench for clock_gen_multi: measures clk_div periods, high times and
// tick-to-rise lag, and checks counters, sticky errors and async reset.
`timescale 1ns/1ps

module tb_clock_gen_multi;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;
    localparam int CNT_W  = 8;

    logic                    clk_in = 1'b0;
    logic                    rst    = 1'b0;
    logic [NUM_CH*DIV_W-1:0] div_ratio;
    logic [NUM_CH-1:0]       div_load;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       clk_div;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       cfg_err;
    logic [NUM_CH*CNT_W-1:0] toggle_counter;

    int n_checks = 0;
    int n_errors = 0;

    clock_gen_multi #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .CNT_W(CNT_W), .RST_RATIO(2)
    ) dut (
        .clk_in(clk_in), .rst(rst), .div_ratio(div_ratio), .div_load(div_load),
        .ch_en(ch_en), .clk_div(clk_div), .tick(tick), .cfg_err(cfg_err),
        .toggle_counter(toggle_counter)
    );

    always #5 clk_in = ~clk_in;

    realtime last_rise [NUM_CH];
    realtime last_per  [NUM_CH];
    realtime last_high [NUM_CH];
    realtime last_tick [NUM_CH];
    logic [NUM_CH-1:0] cd_prev = '0;
    logic [NUM_CH-1:0] tk_prev = '0;

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            last_rise[i] = 0.0; last_per[i] = 0.0;
            last_high[i] = 0.0; last_tick[i] = 0.0;
        end
    end

    always @(clk_div or tick) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (clk_div[i] === 1'b1 && cd_prev[i] == 1'b0) begin
                last_per[i]  = $realtime - last_rise[i];
                last_rise[i] = $realtime;
            end
            if (clk_div[i] === 1'b0 && cd_prev[i] == 1'b1)
                last_high[i] = $realtime - last_rise[i];
            if (tick[i] === 1'b1 && tk_prev[i] == 1'b0)
                last_tick[i] = $realtime;
        end
        cd_prev = (clk_div === 'x) ? '0 : clk_div;
        tk_prev = (tick === 'x) ? '0 : tick;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic at(input realtime t);
        if (t > $realtime) #(t - $realtime);
    endtask

    function automatic logic [31:0] tog(input int ch);
        tog = 32'(toggle_counter[ch*CNT_W +: CNT_W]);
    endfunction

    function automatic logic [31:0] ns(input realtime t);
        ns = 32'(int'(t));
    endfunction

    initial begin
        div_ratio = {8'd2, 8'd2, 8'd2, 8'd2};
        div_load  = '0;
        ch_en     = 4'hF;

        // Reset state
        at(50);
        check_val("rst_clk_div", 32'(clk_div), 0);
        check_val("rst_tick", 32'(tick), 0);
        check_val("rst_cfg_err", 32'(cfg_err), 0);
        check_val("rst_toggle", 32'(toggle_counter), 0);
        at(100);
        rst = 1'b1;

        // Default ratio 2 on all channels for 1000 ns
        at(1100);
        for (int i = 0; i < NUM_CH; i++)
            check_val($sformatf("t1_toggle_ch%0d", i), tog(i), 50);
        check_val("t1_per_ch0", ns(last_per[0]), 20);
        check_val("t1_high_ch0", ns(last_high[0]), 10);
        check_val("t1_high_ch3", ns(last_high[3]), 10);
        ch_en = 4'h0;

        // Program 4/8/5/28 while idle, then enable
        at(1150);
        check_val("t2_idle_clk_div", 32'(clk_div), 0);
        check_val("t2_idle_toggle_ch1", tog(1), 50);
        div_ratio = {8'd28, 8'd5, 8'd8, 8'd4};
        div_load  = 4'hF;
        at(1160);
        div_load  = 4'h0;
        ch_en     = 4'hF;
        at(1761);
        check_val("t2_per_ch0", ns(last_per[0]), 40);
        check_val("t2_high_ch0", ns(last_high[0]), 20);
        check_val("t2_per_ch1", ns(last_per[1]), 80);
        check_val("t2_high_ch1", ns(last_high[1]), 40);
        check_val("t2_per_ch2", ns(last_per[2]), 50);
        check_val("t2_high_ch2", ns(last_high[2]), 25);
        check_val("t2_lag_ch2", ns(last_rise[2] - last_tick[2]), 5);
        check_val("t2_per_ch3", ns(last_per[3]), 280);
        check_val("t2_high_ch3", ns(last_high[3]), 140);

        // Two loads inside one ch0 period: last one wins at the boundary
        at(1820);
        div_ratio[7:0] = 8'd6;
        div_load       = 4'b0001;
        at(1830);
        div_ratio[7:0] = 8'd10;
        at(1840);
        div_load       = 4'b0000;
        at(1850);
        check_val("t3_cur_per_ch0", ns(last_per[0]), 40);
        at(1950);
        check_val("t3_next_per_ch0", ns(last_per[0]), 100);
        check_val("t3_next_high_ch0", ns(last_high[0]), 50);

        // Illegal ratios 0 and 1 on ch1
        div_ratio[15:8] = 8'd0;
        div_load        = 4'b0010;
        at(1960);
        div_ratio[15:8] = 8'd1;
        at(1970);
        div_load        = 4'b0000;
        at(1971);
        check_val("t4_cfg_err", 32'(cfg_err), 32'h2);
        at(2200);
        check_val("t4_per_ch1", ns(last_per[1]), 80);
        check_val("t4_high_ch1", ns(last_high[1]), 40);

        // Disable ch3 mid-high: period completes, then idle
        at(2300);
        ch_en[3] = 1'b0;
        at(2400);
        check_val("t5_still_high_ch3", 32'(clk_div[3]), 1);
        at(2500);
        check_val("t5_low_phase_ch3", 32'(clk_div[3]), 0);
        at(2600);
        check_val("t5_full_high_ch3", ns(last_high[3]), 140);
        at(2900);
        check_val("t5_idle_clk_ch3", 32'(clk_div[3]), 0);
        check_val("t5_hold_toggle_ch3", tog(3), 55);
        at(2901);
        ch_en[3] = 1'b1;
        at(2906);
        check_val("t5_reen_tick_ch3", 32'(tick[3]), 1);
        check_val("t5_reen_clk_ch3", 32'(clk_div[3]), 1);
        check_val("t5_reen_toggle_ch3", tog(3), 56);
        at(2916);
        check_val("t5_tick_width_ch3", 32'(tick[3]), 0);

        // Sticky error survives until reset; reset clears everything
        at(2950);
        check_val("t6_cfg_err_sticky", 32'(cfg_err), 32'h2);
        rst   = 1'b0;
        ch_en = 4'b0001;
        at(2951);
        check_val("t6_rst_clk_div", 32'(clk_div), 0);
        check_val("t6_rst_toggle", 32'(toggle_counter), 0);
        check_val("t6_rst_cfg_err", 32'(cfg_err), 0);
        at(3000);
        rst = 1'b1;
        at(3100);
        check_val("t6_per_ch0", ns(last_per[0]), 20);

        // Toggle counter wrap at R=2, then async reset mid-high
        at(8100);
        check_val("t6_toggle_255", tog(0), 255);
        at(8110);
        check_val("t6_toggle_wrap", tog(0), 0);
        at(8129);
        check_val("t6_high_before_rst", 32'(clk_div[0]), 1);
        check_val("t6_toggle_1", tog(0), 1);
        at(8130);
        rst = 1'b0;
        at(8131);
        check_val("t6_async_clk_div", 32'(clk_div), 0);
        check_val("t6_async_toggle", 32'(toggle_counter), 0);
        check_val("t6_async_tick", 32'(tick), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
